// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encodings,
// chip-enable levels, the grant identifier and a small state helper.
package mem_port_arbiter_pkg;

  // FSM state encodings.
  localparam logic [1:0] ARB_IDLE     = 2'd0;
  localparam logic [1:0] ARB_BUSY_IF  = 2'd1;
  localparam logic [1:0] ARB_BUSY_MEM = 2'd2;

  // Memory chip-enable levels.
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  // Identifies which requester owns (or last owned) the memory port.
  typedef enum logic {
    GRANT_IF  = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

  // True while a transaction is holding the memory port.
  function automatic logic is_busy(input logic [1:0] state);
    return (state == ARB_BUSY_IF) || (state == ARB_BUSY_MEM);
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Transaction watchdog for the memory port arbiter. Counts cycles spent in
// a BUSY state and flags the TIMEOUT-th one so the arbiter can abort an
// access that the memory never completes.
module arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,     // asynchronous, active-low
  input  logic start,   // a grant happens at this edge; restart the count
  input  logic busy,    // arbiter is in a BUSY state this cycle
  output logic expire   // this is the TIMEOUT-th busy cycle
);

  localparam int                 CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Clear when a transaction starts, advance on every busy cycle, hold otherwise.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    count_d = count_q;
    if (start) begin
      count_d = '0;
    end else if (busy) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register; cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking (<=) only; combinational blocks use blocking (=).
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the number of busy cycles already completed.
  assign expire = busy && (count_q == LAST_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one instruction/data memory port between the
// IF stage (fetch) and the MEM stage (load/store). The winning request is
// registered, ram_ce is held until ram_ready or a watchdog timeout, and the
// read data is returned as a registered one-cycle pulse.
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants on
// simultaneous requests; otherwise MEM always beats IF.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,        // asynchronous, active-low

  // IF stage (fetch)
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  input  logic                  if_flush,
  output logic                  if_ack,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,

  // MEM stage (load/store)
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [DATA_W/8-1:0]   mem_be,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_ack,
  output logic                  mem_rvalid,
  output logic [DATA_W-1:0]     mem_rdata,

  // Unified RAM/ROM wrapper
  output logic                  ram_ce,
  output logic                  ram_we,
  output logic [DATA_W/8-1:0]   ram_be,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic                  ram_ready,
  input  logic [DATA_W-1:0]     ram_rdata,

  output logic                  err
);

  localparam int                BE_W          = DATA_W / 8;
  // Instruction fetches are always word aligned.
  localparam logic [ADDR_W-1:0] IF_ALIGN_MASK = ~ADDR_W'(3);

  // FSM and pulse outputs
  logic [1:0]         state_q,      state_d;
  logic               if_ack_q,     if_ack_d;
  logic               mem_ack_q,    mem_ack_d;
  logic               if_rvalid_q,  if_rvalid_d;
  logic [DATA_W-1:0]  if_rdata_q,   if_rdata_d;
  logic               mem_rvalid_q, mem_rvalid_d;
  logic [DATA_W-1:0]  mem_rdata_q,  mem_rdata_d;
  logic               err_q,        err_d;
  logic               flush_q,      flush_d;

  // Latched memory-side request
  logic               ram_ce_q,     ram_ce_d;
  logic               ram_we_q,     ram_we_d;
  logic [BE_W-1:0]    ram_be_q,     ram_be_d;
  logic [ADDR_W-1:0]  ram_addr_q,   ram_addr_d;
  logic [DATA_W-1:0]  ram_wdata_q,  ram_wdata_d;

  // Arbitration
  logic               if_eligible;
  logic               grant_valid;
  grant_e             winner;

  // Watchdog
  logic               wd_busy;
  logic               wd_expire;

`ifdef ARB_ROUND_ROBIN_EN
  grant_e             last_grant_q, last_grant_d;

  // Remember the most recent winner so a tie goes to the other requester.
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_valid) begin
      last_grant_d = winner;
    end
  end

  // Reset to IF so that MEM wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= GRANT_IF;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // Pick a winner among the requests sampled in IDLE. A fetch with flush
  // raised in the same cycle is not eligible.
  always_comb begin
    if_eligible = if_req && !if_flush;
    grant_valid = (state_q == ARB_IDLE) && (if_eligible || mem_req);
    winner      = GRANT_MEM;
    if (!mem_req) begin
      winner = GRANT_IF;
`ifdef ARB_ROUND_ROBIN_EN
    end else if (if_eligible && (last_grant_q == GRANT_MEM)) begin
      winner = GRANT_IF;
`endif
    end
  end

  assign wd_busy = is_busy(state_q);

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .start  (grant_valid),
    .busy   (wd_busy),
    .expire (wd_expire)
  );

  // Next-state and output logic: grant from IDLE, then hold the port until
  // the memory completes or the watchdog expires.
  always_comb begin
    state_d      = state_q;
    if_ack_d     = 1'b0;
    mem_ack_d    = 1'b0;
    if_rvalid_d  = 1'b0;
    if_rdata_d   = '0;
    mem_rvalid_d = 1'b0;
    mem_rdata_d  = '0;
    err_d        = 1'b0;
    flush_d      = flush_q;
    ram_ce_d     = ram_ce_q;
    ram_we_d     = ram_we_q;
    ram_be_d     = ram_be_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;

    unique case (state_q)
      ARB_IDLE: begin
        // ram_ready is ignored here; no transaction is outstanding.
        flush_d = 1'b0;
        if (grant_valid) begin
          ram_ce_d = CHIP_ENABLE;
          if (winner == GRANT_MEM) begin
            state_d     = ARB_BUSY_MEM;
            mem_ack_d   = 1'b1;
            ram_we_d    = mem_we;
            ram_be_d    = mem_be;
            ram_addr_d  = mem_addr;
            ram_wdata_d = mem_wdata;
          end else begin
            state_d     = ARB_BUSY_IF;
            if_ack_d    = 1'b1;
            ram_we_d    = 1'b0;
            ram_be_d    = '1;
            ram_addr_d  = if_addr & IF_ALIGN_MASK;
            ram_wdata_d = '0;
          end
        end
      end

      ARB_BUSY_IF: begin
        // A flush seen at any point in the fetch, including the completion
        // cycle, discards its result; the memory access itself still ends.
        flush_d = flush_q || if_flush;
        if (ram_ready || wd_expire) begin
          state_d     = ARB_IDLE;
          ram_ce_d    = CHIP_DISABLE;
          flush_d     = 1'b0;
          err_d       = !ram_ready;
          if_rvalid_d = !(flush_q || if_flush);
          if (ram_ready && !(flush_q || if_flush)) begin
            if_rdata_d = ram_rdata;
          end
        end
      end

      ARB_BUSY_MEM: begin
        if (ram_ready || wd_expire) begin
          state_d      = ARB_IDLE;
          ram_ce_d     = CHIP_DISABLE;
          err_d        = !ram_ready;
          mem_rvalid_d = 1'b1;
          // Stores and aborted accesses return zero.
          if (ram_ready && !ram_we_q) begin
            mem_rdata_d = ram_rdata;
          end
        end
      end

      default: begin
        state_d  = ARB_IDLE;
        ram_ce_d = CHIP_DISABLE;
        flush_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; everything clears on reset, so ram_ce and
  // the pulses drop as soon as rst goes low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      if_ack_q     <= 1'b0;
      mem_ack_q    <= 1'b0;
      if_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      mem_rvalid_q <= 1'b0;
      mem_rdata_q  <= '0;
      err_q        <= 1'b0;
      flush_q      <= 1'b0;
      ram_ce_q     <= CHIP_DISABLE;
      ram_we_q     <= 1'b0;
      ram_be_q     <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      if_ack_q     <= if_ack_d;
      mem_ack_q    <= mem_ack_d;
      if_rvalid_q  <= if_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      mem_rvalid_q <= mem_rvalid_d;
      mem_rdata_q  <= mem_rdata_d;
      err_q        <= err_d;
      flush_q      <= flush_d;
      ram_ce_q     <= ram_ce_d;
      ram_we_q     <= ram_we_d;
      ram_be_q     <= ram_be_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
    end
  end

  assign if_ack     = if_ack_q;
  assign if_rvalid  = if_rvalid_q;
  assign if_rdata   = if_rdata_q;
  assign mem_ack    = mem_ack_q;
  assign mem_rvalid = mem_rvalid_q;
  assign mem_rdata  = mem_rdata_q;
  assign ram_ce     = ram_ce_q;
  assign ram_we     = ram_we_q;
  assign ram_be     = ram_be_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. Directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
// Honors ARB_ROUND_ROBIN_EN when computing expected grant order.
module tb_mem_port_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int BE_W    = DATA_W / 8;
  localparam int TIMEOUT = 4;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_flush = 1'b0;
  logic              if_ack, if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              mem_req = 1'b0;
  logic              mem_we = 1'b0;
  logic [BE_W-1:0]   mem_be = '0;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic [DATA_W-1:0] mem_wdata = '0;
  logic              mem_ack, mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              ram_ce, ram_we;
  logic [BE_W-1:0]   ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_ready = 1'b0;
  logic [DATA_W-1:0] ram_rdata = '0;
  logic              err;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_flush   (if_flush),
    .if_ack     (if_ack),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .ram_ce     (ram_ce),
    .ram_we     (ram_we),
    .ram_be     (ram_be),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_ready  (ram_ready),
    .ram_rdata  (ram_rdata),
    .err        (err)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    n_total++;
    if ({if_ack, if_rvalid, if_rdata, mem_ack, mem_rvalid, mem_rdata, ram_ce, ram_we,
         ram_be, ram_addr, ram_wdata, err} !== '0)
      $display("FAIL reset_outputs: got ack=%b/%b rvalid=%b/%b ce=%b we=%b be=%h addr=%h err=%b, expected all 0",
               if_ack, mem_ack, if_rvalid, mem_rvalid, ram_ce, ram_we, ram_be, ram_addr, err);
    else n_pass++;
    tick();
    rst = 1'b1;
    // ram_ready with nothing outstanding must be ignored.
    ram_ready = 1'b1;
    ram_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if ({if_rvalid, mem_rvalid, ram_ce, err} !== 4'b0000)
        $display("FAIL idle_ready_ignored: got rvalid=%b/%b ce=%b err=%b, expected 0/0 0 0",
                 if_rvalid, mem_rvalid, ram_ce, err);
      else n_pass++;
    end
    ram_ready = 1'b0;
    ram_rdata = '0;
  endtask

  task automatic test_single_fetch();
    if_req  = 1'b1;
    if_addr = 32'h0000_0007;
    tick();
    n_total++;
    if ({if_ack, mem_ack, ram_ce, ram_we, ram_be, ram_addr} !== {1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h0000_0004})
      $display("FAIL fetch_grant: got ack=%b/%b ce=%b we=%b be=%h addr=%h, expected 1/0 1 0 f 00000004",
               if_ack, mem_ack, ram_ce, ram_we, ram_be, ram_addr);
    else n_pass++;
    if_req = 1'b0;
    tick();
    n_total++;
    if ({if_ack, ram_ce, if_rvalid} !== 3'b010)
      $display("FAIL fetch_busy2: got ack=%b ce=%b rvalid=%b, expected 0 1 0", if_ack, ram_ce, if_rvalid);
    else n_pass++;
    ram_ready = 1'b1;
    ram_rdata = 32'h0022_6293;
    tick();
    ram_ready = 1'b0;
    ram_rdata = '0;
    n_total++;
    if ({if_rvalid, if_rdata, ram_ce, err} !== {1'b1, 32'h0022_6293, 1'b0, 1'b0})
      $display("FAIL fetch_done: got rvalid=%b rdata=%h ce=%b err=%b, expected 1 00226293 0 0",
               if_rvalid, if_rdata, ram_ce, err);
    else n_pass++;
    tick();
    n_total++;
    if (if_rvalid !== 1'b0)
      $display("FAIL fetch_rvalid_pulse: got %b, expected 0", if_rvalid);
    else n_pass++;
  endtask

  task automatic test_contention();
    if_req    = 1'b1;
    if_addr   = 32'h0000_0040;
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_be    = 4'b0011;
    mem_addr  = 32'h0000_0100;
    mem_wdata = 32'hA5A5_1234;
    tick();
    n_total++;
    if ({mem_ack, if_ack, ram_ce, ram_we, ram_be, ram_addr, ram_wdata} !==
        {1'b1, 1'b0, 1'b1, 1'b1, 4'b0011, 32'h0000_0100, 32'hA5A5_1234})
      $display("FAIL contention_mem_first: got ack=%b/%b ce=%b we=%b be=%b addr=%h wdata=%h, expected mem 1 1 0011 00000100 a5a51234",
               mem_ack, if_ack, ram_ce, ram_we, ram_be, ram_addr, ram_wdata);
    else n_pass++;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ram_ready = 1'b1;
    ram_rdata = 32'hDEAD_BEEF;
    tick();
    ram_ready = 1'b0;
    n_total++;
    if ({mem_rvalid, mem_rdata, if_ack, ram_ce} !== {1'b1, 32'h0, 1'b0, 1'b0})
      $display("FAIL store_done: got rvalid=%b rdata=%h if_ack=%b ce=%b, expected 1 00000000 0 0",
               mem_rvalid, mem_rdata, if_ack, ram_ce);
    else n_pass++;
    tick();
    n_total++;
    if ({if_ack, ram_ce, ram_we, ram_be, ram_addr} !== {1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_0040})
      $display("FAIL contention_if_second: got ack=%b ce=%b we=%b be=%h addr=%h, expected 1 1 0 f 00000040",
               if_ack, ram_ce, ram_we, ram_be, ram_addr);
    else n_pass++;
    if_req    = 1'b0;
    ram_ready = 1'b1;
    ram_rdata = 32'h1111_2222;
    tick();
    ram_ready = 1'b0;
    n_total++;
    if ({if_rvalid, if_rdata} !== {1'b1, 32'h1111_2222})
      $display("FAIL contention_if_data: got rvalid=%b rdata=%h, expected 1 11112222", if_rvalid, if_rdata);
    else n_pass++;
  endtask

  // Both requesters hold their requests; the memory answers immediately.
  task automatic test_grant_sequence();
    bit last_mem, exp_mem;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    last_mem  = 1'b0;
    if_req    = 1'b1;
    if_addr   = 32'h0000_0010;
    mem_req   = 1'b1;
    mem_we    = 1'b0;
    mem_be    = 4'hF;
    mem_addr  = 32'h0000_0200;
    ram_ready = 1'b1;
    ram_rdata = 32'h0BAD_F00D;
    for (int i = 0; i < 3; i++) begin
      exp_mem  = RR ? !last_mem : 1'b1;
      last_mem = exp_mem;
      tick();
      n_total++;
      if ({mem_ack, if_ack} !== {exp_mem, !exp_mem})
        $display("FAIL grant_order_%0d: got mem_ack=%b if_ack=%b, expected %b %b", i, mem_ack, if_ack, exp_mem, !exp_mem);
      else n_pass++;
      tick();
      n_total++;
      if ({mem_rvalid, if_rvalid} !== {exp_mem, !exp_mem})
        $display("FAIL grant_rvalid_%0d: got mem_rvalid=%b if_rvalid=%b, expected %b %b",
                 i, mem_rvalid, if_rvalid, exp_mem, !exp_mem);
      else n_pass++;
    end
    if_req    = 1'b0;
    mem_req   = 1'b0;
    ram_ready = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    // Fetch with flush in the same IDLE cycle is not granted.
    if_req   = 1'b1;
    if_addr  = 32'h0000_0080;
    if_flush = 1'b1;
    tick();
    n_total++;
    if ({if_ack, ram_ce} !== 2'b00)
      $display("FAIL idle_flush_blocks: got ack=%b ce=%b, expected 0 0", if_ack, ram_ce);
    else n_pass++;
    if_flush = 1'b0;
    tick();
    n_total++;
    if (if_ack !== 1'b1)
      $display("FAIL flush_fetch_ack: got %b, expected 1", if_ack);
    else n_pass++;
    if_req = 1'b0;
    tick();
    if_flush = 1'b1;
    tick();
    if_flush = 1'b0;
    n_total++;
    if (ram_ce !== 1'b1)
      $display("FAIL flush_ce_held: got %b, expected 1", ram_ce);
    else n_pass++;
    ram_ready = 1'b1;
    ram_rdata = 32'hBAD0_BAD0;
    tick();
    ram_ready = 1'b0;
    n_total++;
    if ({if_rvalid, ram_ce, err} !== 3'b000)
      $display("FAIL flush_suppress: got rvalid=%b ce=%b err=%b, expected 0 0 0", if_rvalid, ram_ce, err);
    else n_pass++;
    tick();
    n_total++;
    if (if_rvalid !== 1'b0)
      $display("FAIL flush_no_late_rvalid: got %b, expected 0", if_rvalid);
    else n_pass++;
    // Following fetch is served normally.
    if_req  = 1'b1;
    if_addr = 32'h0000_0084;
    tick();
    if_req    = 1'b0;
    ram_ready = 1'b1;
    ram_rdata = 32'h0000_0013;
    tick();
    ram_ready = 1'b0;
    n_total++;
    if ({if_rvalid, if_rdata} !== {1'b1, 32'h0000_0013})
      $display("FAIL flush_next_fetch: got rvalid=%b rdata=%h, expected 1 00000013", if_rvalid, if_rdata);
    else n_pass++;
    // Flush arriving in the completion cycle still discards the data.
    if_req  = 1'b1;
    if_addr = 32'h0000_0088;
    tick();
    if_req    = 1'b0;
    if_flush  = 1'b1;
    ram_ready = 1'b1;
    ram_rdata = 32'h7777_7777;
    tick();
    if_flush  = 1'b0;
    ram_ready = 1'b0;
    n_total++;
    if (if_rvalid !== 1'b0)
      $display("FAIL flush_on_ready: got rvalid=%b, expected 0", if_rvalid);
    else n_pass++;
    // Flush does not touch a load.
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_be   = 4'hF;
    mem_addr = 32'h0000_0300;
    tick();
    mem_req   = 1'b0;
    if_flush  = 1'b1;
    ram_ready = 1'b1;
    ram_rdata = 32'hCAFE_F00D;
    tick();
    if_flush  = 1'b0;
    ram_ready = 1'b0;
    n_total++;
    if ({mem_rvalid, mem_rdata} !== {1'b1, 32'hCAFE_F00D})
      $display("FAIL flush_ignores_mem: got rvalid=%b rdata=%h, expected 1 cafef00d", mem_rvalid, mem_rdata);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int ce_cnt;
    mem_req   = 1'b1;
    mem_we    = 1'b0;
    mem_be    = 4'hF;
    mem_addr  = 32'h0000_0400;
    ram_rdata = 32'hFFFF_FFFF;
    tick();
    mem_req = 1'b0;
    ce_cnt  = 0;
    for (int c = 0; c < TIMEOUT + 3 && ram_ce === 1'b1; c++) begin
      ce_cnt++;
      tick();
    end
    n_total++;
    if (ce_cnt !== TIMEOUT)
      $display("FAIL timeout_ce_cycles: got %0d, expected %0d", ce_cnt, TIMEOUT);
    else n_pass++;
    n_total++;
    if ({err, mem_rvalid, mem_rdata, ram_ce} !== {1'b1, 1'b1, 32'h0, 1'b0})
      $display("FAIL timeout_abort: got err=%b rvalid=%b rdata=%h ce=%b, expected 1 1 00000000 0",
               err, mem_rvalid, mem_rdata, ram_ce);
    else n_pass++;
    tick();
    ram_rdata = '0;
    n_total++;
    if ({err, mem_rvalid, ram_ce} !== 3'b000)
      $display("FAIL timeout_pulse: got err=%b rvalid=%b ce=%b, expected 0 0 0", err, mem_rvalid, ram_ce);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_be    = 4'hF;
    mem_addr  = 32'h0000_0500;
    mem_wdata = 32'h0102_0304;
    tick();
    mem_req = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_total++;
    if ({ram_ce, mem_ack, if_ack, mem_rvalid, if_rvalid, err} !== 6'b0)
      $display("FAIL reset_mid_immediate: got ce=%b ack=%b/%b rvalid=%b/%b err=%b, expected all 0",
               ram_ce, mem_ack, if_ack, mem_rvalid, if_rvalid, err);
    else n_pass++;
    tick();
    tick();
    rst       = 1'b1;
    ram_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if ({ram_ce, mem_rvalid, if_rvalid, err} !== 4'b0)
        $display("FAIL reset_mid_after: got ce=%b rvalid=%b/%b err=%b, expected 0 0/0 0",
                 ram_ce, mem_rvalid, if_rvalid, err);
      else n_pass++;
    end
    ram_ready = 1'b0;
  endtask

  // Transaction-level model: pending requests, winner by priority rule,
  // expected bus contents and result from the chosen latency.
  task automatic test_random();
    bit          if_p, mem_p, mwe, last_mem, exp_mem, got, timed_out;
    logic [31:0] ia, ma, mwd, rd, exp_rd, act_rd;
    logic [3:0]  mbe;
    int          lat, c;
    if_p = 1'b0; mem_p = 1'b0; mwe = 1'b0; last_mem = 1'b0;
    ia = '0; ma = '0; mwd = '0; mbe = '0;
    for (int r = 0; r < 60; r++) begin
      if (!if_p && ($urandom_range(0, 1) == 1)) begin
        if_p = 1'b1;
        ia   = $urandom;
      end
      if (!mem_p && (($urandom_range(0, 1) == 1) || !if_p)) begin
        mem_p = 1'b1;
        ma    = $urandom;
        mwe   = 1'($urandom_range(0, 1));
        mbe   = 4'($urandom);
        mwd   = $urandom;
      end
      if_req    = if_p;
      if_addr   = ia;
      mem_req   = mem_p;
      mem_we    = mwe;
      mem_be    = mbe;
      mem_addr  = ma;
      mem_wdata = mwd;
      exp_mem   = mem_p && (!if_p || !RR || !last_mem);
      last_mem  = exp_mem;

      got = 1'b0;
      for (int w = 0; w < 4 && !got; w++) begin
        tick();
        got = if_ack || mem_ack;
      end
      n_total++;
      if (!got) begin
        $display("FAIL rand_ack_wait round %0d: got no ack, expected one within 4 cycles", r);
        if_req  = 1'b0;
        mem_req = 1'b0;
        return;
      end else n_pass++;
      n_total++;
      if ({mem_ack, if_ack} !== {exp_mem, !exp_mem})
        $display("FAIL rand_winner round %0d: got mem_ack=%b if_ack=%b, expected %b %b",
                 r, mem_ack, if_ack, exp_mem, !exp_mem);
      else n_pass++;
      n_total++;
      if (exp_mem) begin
        if ({ram_we, ram_be, ram_addr, ram_wdata} !== {mwe, mbe, ma, mwd})
          $display("FAIL rand_mem_bus round %0d: got we=%b be=%h addr=%h wdata=%h, expected %b %h %h %h",
                   r, ram_we, ram_be, ram_addr, ram_wdata, mwe, mbe, ma, mwd);
        else n_pass++;
        mem_req = 1'b0;
      end else begin
        if ({ram_we, ram_be, ram_addr} !== {1'b0, 4'hF, {ia[31:2], 2'b00}})
          $display("FAIL rand_if_bus round %0d: got we=%b be=%h addr=%h, expected 0 f %h",
                   r, ram_we, ram_be, ram_addr, {ia[31:2], 2'b00});
        else n_pass++;
        if_req = 1'b0;
      end

      lat = $urandom_range(1, TIMEOUT + 1);
      rd  = $urandom;
      c   = 1;
      while (1) begin
        n_total++;
        if (ram_ce !== 1'b1)
          $display("FAIL rand_ce_busy round %0d cycle %0d: got %b, expected 1", r, c, ram_ce);
        else n_pass++;
        ram_ready = (c == lat);
        ram_rdata = (c == lat) ? rd : $urandom;
        tick();
        if (c == lat || c == TIMEOUT) break;
        c++;
      end
      ram_ready = 1'b0;

      timed_out = (lat > TIMEOUT);
      exp_rd    = (timed_out || (exp_mem && mwe)) ? 32'h0 : rd;
      act_rd    = exp_mem ? mem_rdata : if_rdata;
      n_total++;
      if ({err, mem_rvalid, if_rvalid, ram_ce, act_rd} !== {timed_out, exp_mem, !exp_mem, 1'b0, exp_rd})
        $display("FAIL rand_result round %0d: got err=%b rvalid=%b/%b ce=%b rdata=%h, expected %b %b/%b 0 %h",
                 r, err, mem_rvalid, if_rvalid, ram_ce, act_rd, timed_out, exp_mem, !exp_mem, exp_rd);
      else n_pass++;
      if (exp_mem) mem_p = 1'b0;
      else         if_p  = 1'b0;
    end
    if_req  = 1'b0;
    mem_req = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_grant_sequence();
    test_flush();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
